// File: rtl/music_sequencer.sv
// Note-address sequencer: turns the player mode and restart pulse into a beat
// timebase, a wrapping note index, song select and a song-end pulse.
module music_sequencer #(
  parameter int unsigned BEAT_DIV = 12500000,
  parameter int unsigned SONG_LEN = 128,
  parameter int unsigned ADDR_W   = 7
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        state,
  input  logic              oreset,
  input  logic              pause,
  output logic [ADDR_W-1:0] note_index,
  output logic              song_sel,
  output logic              beat,
  output logic              playing,
  output logic              song_end
);

  localparam int unsigned CNT_W = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BEAT_DIV - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(SONG_LEN - 1);

  typedef enum logic [1:0] {
    ST_STOP,
    ST_LOAD,
    ST_RUN
  } fsm_t;

  fsm_t              fsm_q, fsm_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              sel_q, sel_d;
  logic              beat_q, beat_d;
  logic              end_q, end_d;
  logic              play_q, play_d;
  logic              active;
  logic              want_sel;

  assign active   = (state == 2'd1) || (state == 2'd2);
  assign want_sel = (state == 2'd2);

  always_comb begin
    fsm_d  = fsm_q;
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    sel_d  = sel_q;
    beat_d = 1'b0;
    end_d  = 1'b0;

    if (fsm_q == ST_LOAD) sel_d = want_sel;

    if (oreset) begin
      // Restart outranks any mode transition; a mode change rides along
      // through the single LOAD this produces.
      cnt_d = '0;
      idx_d = '0;
      if (fsm_q != ST_STOP) fsm_d = ST_LOAD;
    end else begin
      unique case (fsm_q)
        ST_STOP: begin
          cnt_d = '0;
          idx_d = '0;
          if (active) fsm_d = ST_LOAD;
        end
        ST_LOAD: begin
          cnt_d = '0;
          idx_d = '0;
          fsm_d = active ? ST_RUN : ST_STOP;
        end
        ST_RUN: begin
          if (!active) begin
            fsm_d = ST_STOP;
            cnt_d = '0;
            idx_d = '0;
          end else if (want_sel != sel_q) begin
            fsm_d = ST_LOAD;
            cnt_d = '0;
            idx_d = '0;
          end else if (!pause) begin
            if (cnt_q == CNT_LAST) begin
              cnt_d  = '0;
              beat_d = 1'b1;
              if (idx_q == IDX_LAST) begin
                idx_d = '0;
                end_d = 1'b1;
              end else begin
                idx_d = idx_q + ADDR_W'(1);
              end
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          fsm_d = ST_STOP;
          cnt_d = '0;
          idx_d = '0;
        end
      endcase
    end

    play_d = (fsm_d == ST_RUN) && !pause;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fsm_q  <= ST_STOP;
      cnt_q  <= '0;
      idx_q  <= '0;
      sel_q  <= 1'b0;
      beat_q <= 1'b0;
      end_q  <= 1'b0;
      play_q <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      sel_q  <= sel_d;
      beat_q <= beat_d;
      end_q  <= end_d;
      play_q <= play_d;
    end
  end

  assign note_index = idx_q;
  assign song_sel   = sel_q;
  assign beat       = beat_q;
  assign playing    = play_q;
  assign song_end   = end_q;

endmodule
